alu_mc: RTL and testbench

// - Parametrised multi-cycle ALU for riscy32 pipelined/multi-cycle cores.
// - Executes RV base integer ops (4-bit ALUControl encoding) plus optional M-extension ops.
// - Uses a valid/ready handshake on both sides and a registered result with NZCV-style flags.
// - Sits between decode/issue and writeback; stalls issue while a multiply or divide is in flight.

---
 rtl/alu_mc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake, registered result and NZCV flags.
// Base ops complete one cycle after accept. With ALU_MULDIV_EN defined the M ops are
// built (multiplier with MUL_LAT latency, restoring radix-2 divider). Without it,
// M ops complete in one cycle with rd=0 and out_err=1.
module alu_mc #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALUControl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic [3:0]      flags,
  output logic            out_err
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned XW1   = XLEN + 1;
  localparam int unsigned CNT_W = $clog2(XLEN + MUL_LAT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rd;
  logic [3:0]       r_flags;
  logic             r_err;

  logic             w_acc;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ld;
  logic [XLEN-1:0]  w_res;
  logic [1:0]       w_cv;
  logic             w_err;

  assign in_ready  = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_acc     = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign rd        = r_rd;
  assign flags     = r_flags;
  assign out_err   = r_err;

  // Base integer datapath, evaluated directly on the presented operands.
  logic [SHW-1:0]  w_shamt;
  logic            w_sub;
  logic [XLEN-1:0] w_b_eff;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_base;
  logic [1:0]      w_base_cv;

  assign w_shamt = rs2[SHW-1:0];
  assign w_sub   = ALUControl[3];
  assign w_b_eff = w_sub ? ~rs2 : rs2;
  assign w_sum   = {1'b0, rs1} + {1'b0, w_b_eff} + XW1'(w_sub);

  // Base op result select; C/V only meaningful for ADD/SUB.
  always_comb begin
    w_base    = '0;
    w_base_cv = 2'b00;
    case (ALUControl[3:0])
      4'b0000, 4'b1000: begin
        w_base    = w_sum[XLEN-1:0];
        w_base_cv = {w_sum[XLEN],
                     (rs1[XLEN-1] == w_b_eff[XLEN-1]) && (w_sum[XLEN-1] != rs1[XLEN-1])};
      end
      4'b0001: w_base = rs1 << w_shamt;
      4'b0010: w_base = XLEN'($signed(rs1) < $signed(rs2));
      4'b0011: w_base = XLEN'(rs1 < rs2);
      4'b0100: w_base = rs1 ^ rs2;
      4'b0101: w_base = rs1 >> w_shamt;
      4'b1101: w_base = $unsigned($signed(rs1) >>> w_shamt);
      4'b0110: w_base = rs1 | rs2;
      4'b0111: w_base = rs1 & rs2;
      default: w_base = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic              r_negq;
  logic              r_negr;

  // Multiplier: operands come from the latch while in MUL, else straight from the inputs.
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic [1:0]        w_mop;
  logic [2*XLEN-1:0] w_ma_x;
  logic [2*XLEN-1:0] w_mb_x;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_ma      = (r_state == S_MUL) ? r_a  : rs1;
  assign w_mb      = (r_state == S_MUL) ? r_b  : rs2;
  assign w_mop     = (r_state == S_MUL) ? r_op : ALUControl[1:0];
  assign w_ma_x    = {{XLEN{((w_mop == 2'b01) || (w_mop == 2'b10)) && w_ma[XLEN-1]}}, w_ma};
  assign w_mb_x    = {{XLEN{(w_mop == 2'b01) && w_mb[XLEN-1]}}, w_mb};
  assign w_prod    = w_ma_x * w_mb_x;
  assign w_mul_res = (w_mop == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Divider: magnitudes at accept, one restoring step per DIV cycle, sign fix on the last.
  logic            w_dsigned;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_ovf;
  logic [XLEN:0]   w_rs;
  logic [XLEN:0]   w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_step;
  logic [XLEN-1:0] w_quo_step;
  logic [XLEN-1:0] w_div_res;

  assign w_dsigned  = !ALUControl[0];
  assign w_a_neg    = w_dsigned && rs1[XLEN-1];
  assign w_b_neg    = w_dsigned && rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -rs1 : rs1;
  assign w_b_mag    = w_b_neg ? -rs2 : rs2;
  assign w_ovf      = w_dsigned && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
  assign w_rs       = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_rs - {1'b0, r_dvs};
  assign w_qbit     = !w_diff[XLEN];
  assign w_rem_step = w_qbit ? w_diff[XLEN-1:0] : w_rs[XLEN-1:0];
  assign w_quo_step = {r_quo[XLEN-2:0], w_qbit};
  assign w_div_res  = r_op[1] ? (r_negr ? -w_rem_step : w_rem_step)
                              : (r_negq ? -w_quo_step : w_quo_step);

  // Latch M-op operands at accept and iterate the divider while in DIV.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
    end else if (w_acc && ALUControl[4]) begin
      r_a    <= rs1;
      r_b    <= rs2;
      r_op   <= ALUControl[1:0];
      r_rem  <= '0;
      r_quo  <= w_a_mag;
      r_dvs  <= w_b_mag;
      r_negq <= w_a_neg ^ w_b_neg;
      r_negr <= w_a_neg;
    end else if (r_state == S_DIV) begin
      r_rem  <= w_rem_step;
      r_quo  <= w_quo_step;
    end
  end
`endif

  // Next-state and result-load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ld        = 1'b0;
    w_res       = '0;
    w_cv        = 2'b00;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_acc) begin
          if (!ALUControl[4]) begin
            w_state_nxt = S_DONE;
            w_ld        = 1'b1;
            w_res       = w_base;
            w_cv        = w_base_cv;
          end else begin
`ifdef ALU_MULDIV_EN
            if (!ALUControl[2]) begin
              if (MUL_LAT <= 1) begin
                w_state_nxt = S_DONE;
                w_ld        = 1'b1;
                w_res       = w_mul_res;
              end else begin
                w_state_nxt = S_MUL;
                w_cnt_nxt   = CNT_W'(MUL_LAT - 2);
              end
            end else if (rs2 == '0) begin
              w_state_nxt = S_DONE;
              w_ld        = 1'b1;
              w_res       = ALUControl[1] ? rs1 : '1;
            end else if (w_ovf) begin
              w_state_nxt = S_DONE;
              w_ld        = 1'b1;
              w_res       = ALUControl[1] ? '0 : rs1;
            end else begin
              w_state_nxt = S_DIV;
              w_cnt_nxt   = CNT_W'(XLEN - 1);
            end
`else
            w_state_nxt = S_DONE;
            w_ld        = 1'b1;
            w_err       = 1'b1;
`endif
          end
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          w_ld        = 1'b1;
`ifdef ALU_MULDIV_EN
          w_res       = w_mul_res;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          w_ld        = 1'b1;
`ifdef ALU_MULDIV_EN
          w_res       = w_div_res;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and registered result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_ld) begin
        r_rd    <= w_res;
        r_flags <= {w_res[XLEN-1], (w_res == '0), w_cv};
        r_err   <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc (XLEN=32, MUL_LAT=2).
// M-op vectors are used when ALU_MULDIV_EN is defined, the out_err path otherwise.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ALUControl;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd;
  logic [3:0]  flags;
  logic        out_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .rs1        (rs1),
    .rs2        (rs2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd         (rd),
    .flags      (flags),
    .out_err    (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready low, measure accept-to-valid latency, check the result.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_rd,
                       input logic [3:0] exp_fl, input logic exp_err);
    int lat;
    @(negedge clk);
    ALUControl = op; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h0BAD_F00D; ALUControl = 5'b01000;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"},   32'(lat),     32'(exp_lat));
    check({tag, ".rd"},    rd,           exp_rd);
    check({tag, ".flags"}, 32'(flags),   32'(exp_fl));
    check({tag, ".err"},   32'(out_err), 32'(exp_err));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  // Keep a competing request pending while the result is stalled.
  task automatic hold(input string tag, input logic [31:0] exp_rd, input int n);
    @(negedge clk);
    ALUControl = 5'b00000; rs1 = 32'd1; rs2 = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check({tag, ".valid"},    32'(out_valid), 32'd1);
      check({tag, ".rd"},       rd,             exp_rd);
      check({tag, ".in_ready"}, 32'(in_ready),  32'd0);
    end
  endtask

  logic [4:0]  bb_op [10];
  logic [31:0] bb_a  [10];
  logic [31:0] bb_b  [10];
  logic [31:0] bb_rd [10];

  initial begin
    bb_op[0] = 5'b00000; bb_a[0] = 32'd5;         bb_b[0] = 32'd7;         bb_rd[0] = 32'd12;
    bb_op[1] = 5'b01000; bb_a[1] = 32'd5;         bb_b[1] = 32'd7;         bb_rd[1] = 32'hFFFF_FFFE;
    bb_op[2] = 5'b00001; bb_a[2] = 32'd1;         bb_b[2] = 32'd31;        bb_rd[2] = 32'h8000_0000;
    bb_op[3] = 5'b00010; bb_a[3] = 32'hFFFF_FFFF; bb_b[3] = 32'd1;         bb_rd[3] = 32'd1;
    bb_op[4] = 5'b00011; bb_a[4] = 32'hFFFF_FFFF; bb_b[4] = 32'd1;         bb_rd[4] = 32'd0;
    bb_op[5] = 5'b00100; bb_a[5] = 32'hF0F0_F0F0; bb_b[5] = 32'hFF00_FF00; bb_rd[5] = 32'h0FF0_0FF0;
    bb_op[6] = 5'b00101; bb_a[6] = 32'h8000_0000; bb_b[6] = 32'd4;         bb_rd[6] = 32'h0800_0000;
    bb_op[7] = 5'b01101; bb_a[7] = 32'h8000_0000; bb_b[7] = 32'd4;         bb_rd[7] = 32'hF800_0000;
    bb_op[8] = 5'b00110; bb_a[8] = 32'h0000_00F0; bb_b[8] = 32'h0000_0F00; bb_rd[8] = 32'h0000_0FF0;
    bb_op[9] = 5'b00111; bb_a[9] = 32'h0000_F0F0; bb_b[9] = 32'h0000_0FF0; bb_rd[9] = 32'h0000_00F0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 5'b0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.rd",        rd,             32'd0);
    check("rst.flags",     32'(flags),     32'd0);
    check("rst.err",       32'(out_err),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst.released_ready", 32'(in_ready), 32'd1);

    // Base ops: flags and boundary cases
    do_op("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'd1, 1, 32'd0,         4'b0110, 1'b0); consume("add_wrap");
    do_op("add_ovf",  5'b00000, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 4'b1001, 1'b0); consume("add_ovf");
    do_op("sub_neg",  5'b01000, 32'd20,        32'd30, 1, 32'hFFFF_FFF6, 4'b1000, 1'b0);
    hold("hold_sub", 32'hFFFF_FFF6, 5);
    consume("sub_neg");
    do_op("sub_zero", 5'b01000, 32'd20,        32'd20, 1, 32'd0,         4'b0110, 1'b0); consume("sub_zero");
    do_op("sub_ovf",  5'b01000, 32'h8000_0000, 32'd1,  1, 32'h7FFF_FFFF, 4'b0011, 1'b0); consume("sub_ovf");
    do_op("sra",      5'b01101, 32'h8000_0000, 32'd4,  1, 32'hF800_0000, 4'b1000, 1'b0); consume("sra");
    do_op("sll_amt",  5'b00001, 32'd1,         32'd33, 1, 32'd2,         4'b0000, 1'b0); consume("sll_amt");
    do_op("bad_code", 5'b01001, 32'd9,         32'd9,  1, 32'd0,         4'b0100, 1'b0); consume("bad_code");

    // Back-to-back base ops at one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ALUControl = bb_op[i]; rs1 = bb_a[i]; rs2 = bb_b[i]; in_valid = 1'b1;
      check($sformatf("b2b%0d.in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check($sformatf("b2b%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b%0d.rd", i), rd, bb_rd[i]);
    end
    consume("b2b");

    // Reset while a result is pending
    do_op("pre_rst", 5'b00000, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_held.valid", 32'(out_valid), 32'd0);
    check("rst_held.rd",    rd,             32'd0);
    check("rst_held.flags", 32'(flags),     32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef ALU_MULDIV_EN
    do_op("mulhu",    5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 4'b1000, 1'b0); consume("mulhu");
    do_op("mul",      5'b10000, 32'd3,         32'd4,         2, 32'd12,        4'b0000, 1'b0); consume("mul");
    do_op("mul_lo0",  5'b10000, 32'h0001_0000, 32'h0001_0000, 2, 32'd0,         4'b0100, 1'b0); consume("mul_lo0");
    do_op("mulh",     5'b10001, 32'hFFFF_FFFE, 32'd3,         2, 32'hFFFF_FFFF, 4'b1000, 1'b0); consume("mulh");
    do_op("mulhsu",   5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 4'b1000, 1'b0); consume("mulhsu");
    do_op("rem",      5'b10110, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 4'b1000, 1'b0); consume("rem");
    do_op("rem_nd",   5'b10110, 32'd7,         32'hFFFF_FFFE, 33, 32'd1,         4'b0000, 1'b0); consume("rem_nd");
    do_op("divu",     5'b10101, 32'd100,       32'd7,         33, 32'd14,        4'b0000, 1'b0); consume("divu");
    do_op("remu",     5'b10111, 32'd100,       32'd7,         33, 32'd2,         4'b0000, 1'b0); consume("remu");
    do_op("divu_z",   5'b10101, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 4'b1000, 1'b0); consume("divu_z");
    do_op("remu_z",   5'b10111, 32'd5,         32'd0,         1, 32'd5,         4'b0000, 1'b0); consume("remu_z");
    do_op("div_ovf",  5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 4'b1000, 1'b0); consume("div_ovf");
    do_op("rem_ovf",  5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         4'b0100, 1'b0); consume("rem_ovf");
    do_op("div",      5'b10100, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 4'b1000, 1'b0);
    hold("hold_div", 32'hFFFF_FFFD, 5);
    consume("div");

    // Reset ten cycles into a divide
    @(negedge clk);
    ALUControl = 5'b10100; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_div.valid",    32'(out_valid), 32'd0);
    check("rst_div.rd",       rd,             32'd0);
    check("rst_div.in_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("post_rst_add", 5'b00000, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1'b0); consume("post_rst_add");
`else
    do_op("mul_dis",  5'b10000, 32'd3, 32'd4, 1, 32'd0, 4'b0100, 1'b1); consume("mul_dis");
    do_op("div_dis",  5'b10100, 32'd9, 32'd3, 1, 32'd0, 4'b0100, 1'b1); consume("div_dis");
    do_op("post_dis_add", 5'b00000, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1'b0); consume("post_dis_add");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
